// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Purpose  : Shared definitions for the multi-cycle AR/T processor:
//            opcode constants, ALU function codes, FSM state encoding and
//            instruction field bit positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

   // Opcodes; every other 5-bit value is illegal and halts the core
   localparam logic [4:0] OP_AR = 5'd0;
   localparam logic [4:0] OP_T  = 5'd1;

   // Instruction field positions (32-bit instruction word)
   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 27;
   localparam int FUNC_MSB = 26;
   localparam int FUNC_LSB = 23;
   localparam int RS1_MSB  = 22;   // AR source 1
   localparam int RS1_LSB  = 19;
   localparam int RS2_MSB  = 18;   // AR source 2
   localparam int RS2_LSB  = 15;
   localparam int RD_MSB   = 14;   // AR destination
   localparam int RD_LSB   = 11;
   localparam int T_RD_MSB = 22;   // T destination shares the rs1 slot
   localparam int T_RD_LSB = 19;
   localparam int IMM_MSB  = 18;   // T constant
   localparam int IMM_LSB  = 0;
   localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

   // ALU function codes; codes 8..15 are legal and produce zero
   typedef enum logic [3:0] {
      FN_ADD = 4'd0,
      FN_SUB = 4'd1,
      FN_AND = 4'd2,
      FN_OR  = 4'd3,
      FN_XOR = 4'd4,
      FN_SLT = 4'd5,
      FN_SLL = 4'd6,
      FN_SRL = 4'd7
   } alu_func_e;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_HALT      = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/proc_regfile.sv
`default_nettype none
// ============================================================================
// Module   : proc_regfile
// Purpose  : 2**REG_AW x DATA_W register file, two combinational read ports,
//            one synchronous write port, synchronous clear on RESET.
// Ports    : CLK, RESET            - clock, synchronous active-high reset
//            rd_addr_a/rd_data_a   - read port A
//            rd_addr_b/rd_data_b   - read port B
//            wr_en/wr_addr/wr_data - write port (rising edge)
// Revision : 1.0 - initial release
// ============================================================================
module proc_regfile #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [REG_AW-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [REG_AW-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int DEPTH = 2 ** REG_AW;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data_a = mem_q[rd_addr_a];
   assign rd_data_b = mem_q[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/proc_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : proc_multicycle
// Purpose  : Multi-cycle AR/T processor. FETCH/DECODE/EXECUTE/WRITEBACK FSM
//            with a req/ack instruction fetch of arbitrary latency. Owns PC,
//            instruction register, ALU operand/result latches, register file.
// Ports    : CLK, RESET           - clock, synchronous active-high reset
//            start_pc             - PC loaded while RESET is high
//            imem_req/imem_addr   - fetch request and address (= pc)
//            imem_ack/imem_rdata  - fetch completion and instruction word
//            retire               - one-cycle pulse in WRITEBACK
//            halted/illegal       - core stopped / stopped on bad opcode
//            cycle_cnt/retire_cnt - performance counters (PROC_PERF_CNT_EN)
// Options  : `define PROC_PERF_CNT_EN to add the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module proc_multicycle
   import proc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 4,
   parameter int PC_STEP = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] start_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        retire,
   output logic        halted,
   output logic        illegal
`ifdef PROC_PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retire_cnt
`endif
);

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              req_q, req_d;
   logic              retire_q, retire_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;

   // ------------------------------------------------------------------
   // Instruction field decode (from the instruction register)
   // ------------------------------------------------------------------
   logic [4:0]              opcode;
   logic [3:0]              func;
   logic                    is_t;
   logic                    is_legal;
   logic [REG_AW-1:0]       rs1_addr;
   logic [REG_AW-1:0]       rs2_addr;
   logic [REG_AW-1:0]       wr_addr;
   logic signed [IMM_W-1:0] imm_s;
   logic [DATA_W-1:0]       imm_ext;

   assign opcode   = instr_q[OPC_MSB:OPC_LSB];
   assign func     = instr_q[FUNC_MSB:FUNC_LSB];
   assign is_t     = (opcode == OP_T);
   assign is_legal = (opcode == OP_AR) || is_t;
   assign rs1_addr = REG_AW'(instr_q[RS1_MSB:RS1_LSB]);
   assign rs2_addr = REG_AW'(instr_q[RS2_MSB:RS2_LSB]);
   assign wr_addr  = is_t ? REG_AW'(instr_q[T_RD_MSB:T_RD_LSB])
                          : REG_AW'(instr_q[RD_MSB:RD_LSB]);
   assign imm_s    = instr_q[IMM_MSB:IMM_LSB];
   // Size cast of a signed operand sign-extends to DATA_W
   assign imm_ext  = DATA_W'(imm_s);

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rf_we;

   assign rf_we = (state_q == ST_WRITEBACK);

   proc_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .CLK       (CLK),
      .RESET     (RESET),
      .rd_addr_a (rs1_addr),
      .rd_data_a (rd_data_a),
      .rd_addr_b (rs2_addr),
      .rd_data_b (rd_data_b),
      .wr_en     (rf_we),
      .wr_addr   (wr_addr),
      .wr_data   (result_q)
   );

   // ------------------------------------------------------------------
   // ALU (operates on the latched operands)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] alu_out;

   always_comb begin
      alu_out = '0;
      case (func)
         FN_ADD:  alu_out = a_q + b_q;
         FN_SUB:  alu_out = a_q - b_q;
         FN_AND:  alu_out = a_q & b_q;
         FN_OR:   alu_out = a_q | b_q;
         FN_XOR:  alu_out = a_q ^ b_q;
         FN_SLT:  alu_out = DATA_W'($signed(a_q) < $signed(b_q));
         FN_SLL:  alu_out = a_q << b_q[4:0];
         FN_SRL:  alu_out = a_q >> b_q[4:0];
         default: alu_out = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      req_d     = req_q;
      retire_d  = 1'b0;
      halted_d  = halted_q;
      illegal_d = illegal_q;

      case (state_q)
         ST_FETCH: begin
            // The request register comes up one cycle after reset; an ack
            // only completes the fetch while the request is actually out.
            req_d = 1'b1;
            if (req_q && imem_ack) begin
               instr_d = imem_rdata;
               pc_d    = pc_q + 32'(PC_STEP);
               req_d   = 1'b0;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            a_d = rd_data_a;
            b_d = rd_data_b;
            if (is_legal) begin
               state_d = ST_EXECUTE;
            end else begin
               state_d   = ST_HALT;
               halted_d  = 1'b1;
               illegal_d = 1'b1;
            end
         end
         ST_EXECUTE: begin
            result_d = is_t ? imm_ext : alu_out;
            retire_d = 1'b1;          // lands in the WRITEBACK cycle
            state_d  = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            req_d   = 1'b1;           // request is up in the first FETCH cycle
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            req_d = 1'b0;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_FETCH;
         pc_q      <= start_pc;
         instr_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         req_q     <= 1'b0;
         retire_q  <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
         req_q     <= req_d;
         retire_q  <= retire_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign retire    = retire_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;

`ifdef PROC_PERF_CNT_EN
   // ------------------------------------------------------------------
   // Performance counters (free-running, wrap at 2**32)
   // ------------------------------------------------------------------
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      cycle_cnt_d  = halted_q ? cycle_cnt_q : cycle_cnt_q + 32'd1;
      retire_cnt_d = retire_cnt_q + 32'(retire_q);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_multicycle
// Purpose  : Self-checking bench for proc_multicycle. A vector table of
//            instructions with expected register results is fed through a
//            req/ack memory model; expected writes go to a scoreboard queue
//            and are compared after each retire. Hand-written sequences cover
//            the illegal-opcode halt and reset during a pending fetch.
// Options  : `define PROC_PERF_CNT_EN to also check the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_multicycle;
   import proc_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] start_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        retire;
   logic        halted;
   logic        illegal;
`ifdef PROC_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;
`endif

   proc_multicycle dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .start_pc   (start_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .retire     (retire),
      .halted     (halted),
      .illegal    (illegal)
`ifdef PROC_PERF_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .retire_cnt (retire_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int pos_cnt = 0;
   always @(posedge CLK) pos_cnt <= pos_cnt + 1;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_pc;
   int exp_retires;

   typedef struct {
      logic [31:0] word;
      logic [3:0]  rd;
      logic [31:0] exp_val;
   } vec_t;

   typedef struct {
      logic [3:0]  rd;
      logic [31:0] val;
   } sb_t;

   sb_t sb_q[$];
   vec_t vecs[20];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] enc_ar(input logic [3:0] fn, input logic [3:0] rs1,
                                          input logic [3:0] rs2, input logic [3:0] rd);
      return {OP_AR, fn, rs1, rs2, rd, 11'd0};
   endfunction

   function automatic logic [31:0] enc_t(input logic [3:0] rd, input logic [18:0] imm);
      return {OP_T, 4'd0, rd, imm};
   endfunction

   task automatic wait_req(input string tag);
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check32({tag, "_req"}, {31'd0, imem_req}, 32'd1);
   endtask

   // Reset the core, check reset state, release and check the request rises.
   task automatic do_reset(input logic [31:0] pc);
      RESET      = 1'b1;
      start_pc   = pc;
      imem_ack   = 1'b1;                  // must be ignored under reset
      imem_rdata = enc_t(4'd2, 19'h55);
      repeat (2) @(negedge CLK);
      check32("rst_req",     {31'd0, imem_req}, 32'd0);
      check32("rst_retire",  {31'd0, retire},   32'd0);
      check32("rst_halted",  {31'd0, halted},   32'd0);
      check32("rst_illegal", {31'd0, illegal},  32'd0);
      check32("rst_addr",    imem_addr,         pc);
      check32("rst_r2",      dut.u_regfile.mem_q[2], 32'd0);
      check32("rst_r4",      dut.u_regfile.mem_q[4], 32'd0);
`ifdef PROC_PERF_CNT_EN
      check32("rst_cycle_cnt",  cycle_cnt,  32'd0);
      check32("rst_retire_cnt", retire_cnt, 32'd0);
`endif
      imem_ack    = 1'b0;
      RESET       = 1'b0;
      exp_pc      = pc;
      exp_retires = 0;
      @(negedge CLK);
      check32("req_after_reset", {31'd0, imem_req}, 32'd1);
   endtask

   // One instruction through the memory model: optional ack wait, stray acks
   // outside FETCH, retire timing and scoreboard compare of the written reg.
   task automatic run_vec(input string tag, input logic [31:0] word, input int wait_cyc,
                          input logic [3:0] rd, input logic [31:0] exp_val);
      sb_t e;
      int  k;
      wait_req(tag);
      check32({tag, "_addr"}, imem_addr, exp_pc);
      for (int w = 0; w < wait_cyc; w++) begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         @(negedge CLK);
         check32({tag, "_req_hold"},  {31'd0, imem_req}, 32'd1);
         check32({tag, "_addr_hold"}, imem_addr, exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      sb_q.push_back('{rd, exp_val});
      @(negedge CLK);
      exp_pc     = exp_pc + 32'd4;
      imem_rdata = 32'hFFFF_FFFF;           // stray ack with an illegal opcode
      check32({tag, "_state_dec"}, 32'(dut.state_q), 32'(ST_DECODE));
      check32({tag, "_pc_adv"},    imem_addr, exp_pc);
      check32({tag, "_req_drop"},  {31'd0, imem_req}, 32'd0);
      k = 0;
      do begin
         @(negedge CLK);
         k++;
      end while (retire !== 1'b1 && k < 6);
      check32({tag, "_retire_lat"}, k, 32'd2);
      @(negedge CLK);
      imem_ack = 1'b0;
      check32({tag, "_retire_pulse"}, {31'd0, retire}, 32'd0);
      exp_retires++;
      if (sb_q.size() == 0) begin
         check32({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check32({tag, "_reg"}, dut.u_regfile.mem_q[e.rd], e.val);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      logic [31:0] c0;
      c0 = '0;

      vecs[0]  = '{enc_t(4'd3, 19'h7FFFF),          4'd3,  32'hFFFF_FFFF};
      vecs[1]  = '{enc_t(4'd1, 19'h00005),          4'd1,  32'h0000_0005};
      vecs[2]  = '{enc_t(4'd2, 19'h00007),          4'd2,  32'h0000_0007};
      vecs[3]  = '{enc_ar(4'd0, 4'd1, 4'd2, 4'd4),  4'd4,  32'h0000_000C};
      vecs[4]  = '{enc_ar(4'd1, 4'd1, 4'd2, 4'd5),  4'd5,  32'hFFFF_FFFE};
      vecs[5]  = '{enc_ar(4'd5, 4'd5, 4'd1, 4'd6),  4'd6,  32'h0000_0001};
      vecs[6]  = '{enc_t(4'd7, 19'h40000),          4'd7,  32'hFFFC_0000};
      vecs[7]  = '{enc_ar(4'd2, 4'd3, 4'd2, 4'd8),  4'd8,  32'h0000_0007};
      vecs[8]  = '{enc_ar(4'd3, 4'd1, 4'd2, 4'd9),  4'd9,  32'h0000_0007};
      vecs[9]  = '{enc_ar(4'd4, 4'd1, 4'd2, 4'd10), 4'd10, 32'h0000_0002};
      vecs[10] = '{enc_ar(4'd6, 4'd1, 4'd2, 4'd11), 4'd11, 32'h0000_0280};
      vecs[11] = '{enc_ar(4'd7, 4'd7, 4'd1, 4'd12), 4'd12, 32'h07FF_E000};
      vecs[12] = '{enc_ar(4'd5, 4'd1, 4'd5, 4'd6),  4'd6,  32'h0000_0000};
      vecs[13] = '{enc_ar(4'd9, 4'd1, 4'd2, 4'd3),  4'd3,  32'h0000_0000};
      vecs[14] = '{enc_t(4'd0, 19'h00001),          4'd0,  32'h0000_0001};
      vecs[15] = '{enc_ar(4'd0, 4'd0, 4'd0, 4'd0),  4'd0,  32'h0000_0002};
      vecs[16] = '{enc_ar(4'd6, 4'd1, 4'd7, 4'd14), 4'd14, 32'h0000_0005};
      vecs[17] = '{enc_ar(4'd0, 4'd5, 4'd2, 4'd15), 4'd15, 32'h0000_0005};
      vecs[18] = '{enc_t(4'd13, 19'h7FFFF),         4'd13, 32'hFFFF_FFFF};
      vecs[19] = '{enc_ar(4'd6, 4'd1, 4'd13, 4'd12),4'd12, 32'h8000_0000};

      RESET      = 1'b1;
      start_pc   = 32'h100;
      imem_ack   = 1'b0;
      imem_rdata = '0;

      // ---- table-driven program from 0x100 ----
      do_reset(32'h100);
      p0 = pos_cnt;
`ifdef PROC_PERF_CNT_EN
      c0 = cycle_cnt;
`endif
      for (int i = 0; i < 20; i++) begin
         run_vec($sformatf("v%0d", i), vecs[i].word, i % 4, vecs[i].rd, vecs[i].exp_val);
      end
`ifdef PROC_PERF_CNT_EN
      check32("cycle_cnt_delta", cycle_cnt - c0, 32'(pos_cnt - p0));
      check32("retire_cnt_tbl",  retire_cnt, 32'(exp_retires));
`endif

      // ---- illegal opcode 9 halts the core ----
      wait_req("ill");
      check32("ill_addr", imem_addr, exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = {5'd9, 27'd0};
      @(negedge CLK);
      check32("ill_dec_halted", {31'd0, halted}, 32'd0);
      imem_rdata = enc_t(4'd1, 19'h00033);
      @(negedge CLK);
      check32("ill_halted",  {31'd0, halted},  32'd1);
      check32("ill_illegal", {31'd0, illegal}, 32'd1);
`ifdef PROC_PERF_CNT_EN
      c0 = cycle_cnt;
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check32($sformatf("ill_req_%0d", i),    {31'd0, imem_req}, 32'd0);
         check32($sformatf("ill_sticky_%0d", i), {31'd0, halted & illegal}, 32'd1);
         check32($sformatf("ill_retire_%0d", i), {31'd0, retire}, 32'd0);
      end
      check32("ill_r1_kept", dut.u_regfile.mem_q[1], 32'h0000_0005);
`ifdef PROC_PERF_CNT_EN
      check32("ill_cycle_frozen", cycle_cnt, c0);
`endif
      imem_ack = 1'b0;

      // ---- reset clears the halt; registers cleared ----
      do_reset(32'h300);
      check32("post_halt_illegal", {31'd0, illegal}, 32'd0);
      check32("post_halt_r0", dut.u_regfile.mem_q[0], 32'd0);

      // ---- reset while a fetch is pending ----
      for (int w = 0; w < 2; w++) begin
         @(negedge CLK);
         check32($sformatf("pend_req_%0d", w), {31'd0, imem_req}, 32'd1);
         check32($sformatf("pend_addr_%0d", w), imem_addr, 32'h300);
      end
      RESET      = 1'b1;
      start_pc   = 32'h400;
      imem_ack   = 1'b1;
      imem_rdata = enc_t(4'd9, 19'h01234);
      @(negedge CLK);
      check32("midrst_req",   {31'd0, imem_req}, 32'd0);
      check32("midrst_addr",  imem_addr, 32'h400);
      check32("midrst_instr", dut.instr_q, 32'd0);
      check32("midrst_state", 32'(dut.state_q), 32'(ST_FETCH));
      RESET       = 1'b0;
      imem_ack    = 1'b0;
      exp_pc      = 32'h400;
      exp_retires = 0;
      @(negedge CLK);
      check32("midrst_req_up", {31'd0, imem_req}, 32'd1);
      check32("midrst_r9",     dut.u_regfile.mem_q[9], 32'd0);
      run_vec("post", enc_t(4'd9, 19'h01234), 1, 4'd9, 32'h0000_1234);
      run_vec("post2", enc_ar(4'd0, 4'd9, 4'd9, 4'd10), 0, 4'd10, 32'h0000_2468);
`ifdef PROC_PERF_CNT_EN
      check32("retire_cnt_post", retire_cnt, 32'(exp_retires));
`endif
      check32("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
